// File: rtl/alu_arbiter_if.sv
// Signal bundle between two requesters, the shared combinational ALU and the
// response consumer; the arbiter side uses the slave modport.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [4:0]  req0_sel;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [4:0]  req1_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_sel;
    logic [63:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_data;
    logic        rsp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  alu_out, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output alu_out, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters;
// holds operands for a settle window and returns the captured result.
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned MAX_SEL       = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    function automatic logic sel_illegal(input logic [4:0] sel);
        return (sel > 5'(MAX_SEL));
    endfunction

    logic [1:0]       state_q, state_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      alu_a_q, alu_a_d;
    logic [31:0]      alu_b_q, alu_b_d;
    logic [4:0]       alu_sel_q, alu_sel_d;
    logic             rsp_id_q, rsp_id_d;
    logic [63:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             grant0_s, grant1_s;
    logic [31:0]      pick_a_s, pick_b_s;
    logic [4:0]       pick_sel_s;

    // Grant decision; ready is withheld while reset is asserted
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0_s = ~prio_q;
                grant1_s = prio_q;
            end else begin
                grant0_s = bus.req0_valid;
                grant1_s = bus.req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        pick_a_s   = bus.req0_a;
        pick_b_s   = bus.req0_b;
        pick_sel_s = bus.req0_sel;
        if (grant1_s) begin
            pick_a_s   = bus.req1_a;
            pick_b_s   = bus.req1_b;
            pick_sel_s = bus.req1_sel;
        end else begin
            pick_a_s   = bus.req0_a;
            pick_b_s   = bus.req0_b;
            pick_sel_s = bus.req0_sel;
        end
    end

    // Next-state logic for the IDLE/ISSUE/RESP sequencer
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0_s || grant1_s) begin
                    rsp_id_d = grant1_s;
                    prio_d   = grant0_s;
                    cnt_d    = '0;
                    // Illegal opcodes bypass the ALU so its inputs stay untouched
                    if (sel_illegal(pick_sel_s)) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = 64'h0;
                        state_d    = ST_RESP;
                    end else begin
                        alu_a_d   = pick_a_s;
                        alu_b_d   = pick_b_s;
                        alu_sel_d = pick_sel_s;
                        state_d   = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == CNT_LAST) begin
                    rsp_data_d = bus.alu_out;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            prio_q     <= 1'b0;
            cnt_q      <= '0;
            alu_a_q    <= 32'h0;
            alu_b_q    <= 32'h0;
            alu_sel_q  <= 5'h0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= 64'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with a 1-cycle settle window,
// one with a 3-cycle window, each driving an ALU stub returning {b, a}.
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic eid;

    alu_arbiter_if ia ();
    alu_arbiter_if ib ();

    assign ia.alu_out = {ia.alu_b, ia.alu_a};
    assign ib.alu_out = {ib.alu_b, ib.alu_a};

    alu_arbiter #(.SETTLE_CYCLES(1), .MAX_SEL(14)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    alu_arbiter #(.SETTLE_CYCLES(3), .MAX_SEL(14)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ia.req0_valid = 1'b1; ia.req0_a = 32'h0; ia.req0_b = 32'h0; ia.req0_sel = 5'h0;
        ia.req1_valid = 1'b0; ia.req1_a = 32'h0; ia.req1_b = 32'h0; ia.req1_sel = 5'h0;
        ia.rsp_ready  = 1'b0;
        ib.req0_valid = 1'b0; ib.req0_a = 32'h0; ib.req0_b = 32'h0; ib.req0_sel = 5'h0;
        ib.req1_valid = 1'b0; ib.req1_a = 32'h0; ib.req1_b = 32'h0; ib.req1_sel = 5'h0;
        ib.rsp_ready  = 1'b0;
        tick();
        tick();
        // Reset state, with req0 valid to confirm ready is held low
        chk("rst_ready0", ia.req0_ready, 64'h0);
        chk("rst_ready1", ia.req1_ready, 64'h0);
        chk("rst_rsp_valid", ia.rsp_valid, 64'h0);
        chk("rst_alu_a", ia.alu_a, 64'h0);
        chk("rst_alu_b", ia.alu_b, 64'h0);
        chk("rst_alu_sel", ia.alu_sel, 64'h0);
        chk("rst_rsp_id", ia.rsp_id, 64'h0);
        chk("rst_rsp_data", ia.rsp_data, 64'h0);
        chk("rst_rsp_err", ia.rsp_err, 64'h0);
        ia.req0_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single op on requester 0
        ia.req0_valid = 1'b1; ia.req0_a = 32'h0000000A; ia.req0_b = 32'h00000002; ia.req0_sel = 5'h01;
        ia.rsp_ready = 1'b1;
        #1;
        chk("single_ready0", ia.req0_ready, 64'h1);
        chk("single_ready1", ia.req1_ready, 64'h0);
        tick();
        ia.req0_valid = 1'b0;
        chk("single_alu_sel", ia.alu_sel, 64'h01);
        chk("single_alu_a", ia.alu_a, 64'h0000000A);
        chk("single_issue_valid", ia.rsp_valid, 64'h0);
        tick();
        chk("single_rsp_valid", ia.rsp_valid, 64'h1);
        chk("single_rsp_id", ia.rsp_id, 64'h0);
        chk("single_rsp_data", ia.rsp_data, 64'h000000020000000A);
        chk("single_rsp_err", ia.rsp_err, 64'h0);
        tick();
        chk("single_done", ia.rsp_valid, 64'h0);

        // Illegal opcode on requester 1
        ia.req1_valid = 1'b1; ia.req1_a = 32'h11; ia.req1_b = 32'h22; ia.req1_sel = 5'h1F;
        #1;
        chk("illegal_ready1", ia.req1_ready, 64'h1);
        tick();
        ia.req1_valid = 1'b0;
        chk("illegal_rsp_valid", ia.rsp_valid, 64'h1);
        chk("illegal_rsp_id", ia.rsp_id, 64'h1);
        chk("illegal_rsp_err", ia.rsp_err, 64'h1);
        chk("illegal_rsp_data", ia.rsp_data, 64'h0);
        chk("illegal_alu_a", ia.alu_a, 64'h0000000A);
        chk("illegal_alu_b", ia.alu_b, 64'h00000002);
        chk("illegal_alu_sel", ia.alu_sel, 64'h01);
        tick();

        // Contention: both valid, grants alternate starting with 0
        ia.req0_valid = 1'b1; ia.req0_a = 32'h100; ia.req0_b = 32'h200; ia.req0_sel = 5'h02;
        ia.req1_valid = 1'b1; ia.req1_a = 32'h300; ia.req1_b = 32'h400; ia.req1_sel = 5'h03;
        for (int i = 0; i < 4; i++) begin
            eid = i[0];
            #1;
            chk("cont_ready0", ia.req0_ready, {63'h0, ~eid});
            chk("cont_ready1", ia.req1_ready, {63'h0, eid});
            tick();
            chk("cont_alu_sel", ia.alu_sel, eid ? 64'h03 : 64'h02);
            tick();
            chk("cont_rsp_valid", ia.rsp_valid, 64'h1);
            chk("cont_rsp_id", ia.rsp_id, {63'h0, eid});
            chk("cont_rsp_data", ia.rsp_data, eid ? 64'h0000040000000300 : 64'h0000020000000100);
            tick();
        end
        ia.req0_valid = 1'b0;
        ia.req1_valid = 1'b0;

        // Backpressure: response held for 5 cycles, requester 1 waits
        ia.rsp_ready = 1'b0;
        ia.req0_valid = 1'b1; ia.req0_a = 32'h5; ia.req0_b = 32'h6; ia.req0_sel = 5'h04;
        #1;
        chk("bp_ready0", ia.req0_ready, 64'h1);
        tick();
        ia.req0_valid = 1'b0;
        ia.req1_valid = 1'b1; ia.req1_a = 32'h7; ia.req1_b = 32'h8; ia.req1_sel = 5'h05;
        #1;
        chk("bp_issue_ready1", ia.req1_ready, 64'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", ia.rsp_valid, 64'h1);
            chk("bp_rsp_id", ia.rsp_id, 64'h0);
            chk("bp_rsp_data", ia.rsp_data, 64'h0000000600000005);
            chk("bp_ready0", ia.req0_ready, 64'h0);
            chk("bp_ready1", ia.req1_ready, 64'h0);
            tick();
        end
        ia.rsp_ready = 1'b1;
        #1;
        chk("bp_release_valid", ia.rsp_valid, 64'h1);
        tick();
        chk("bp_idle_valid", ia.rsp_valid, 64'h0);
        chk("bp_idle_ready1", ia.req1_ready, 64'h1);
        tick();
        ia.req1_valid = 1'b0;
        chk("bp_next_alu_sel", ia.alu_sel, 64'h05);
        tick();
        chk("bp_next_rsp_id", ia.rsp_id, 64'h1);
        chk("bp_next_rsp_data", ia.rsp_data, 64'h0000000800000007);
        tick();

        // Opcode boundary: 15 illegal, 14 legal
        ia.req0_valid = 1'b1; ia.req0_sel = 5'h0F;
        tick();
        ia.req0_valid = 1'b0;
        chk("sel15_err", ia.rsp_err, 64'h1);
        chk("sel15_alu_sel", ia.alu_sel, 64'h05);
        tick();
        ia.req1_valid = 1'b1; ia.req1_a = 32'h9; ia.req1_b = 32'hC; ia.req1_sel = 5'h0E;
        tick();
        ia.req1_valid = 1'b0;
        chk("sel14_alu_sel", ia.alu_sel, 64'h0E);
        tick();
        chk("sel14_err", ia.rsp_err, 64'h0);
        chk("sel14_data", ia.rsp_data, 64'h0000000C00000009);
        tick();

        // Settle sweep on the 3-cycle instance
        ib.rsp_ready = 1'b1;
        ib.req0_valid = 1'b1; ib.req0_a = 32'hAA; ib.req0_b = 32'hBB; ib.req0_sel = 5'h06;
        #1;
        chk("settle_ready0", ib.req0_ready, 64'h1);
        tick();
        ib.req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("settle_alu_sel", ib.alu_sel, 64'h06);
            chk("settle_alu_a", ib.alu_a, 64'hAA);
            chk("settle_hold_valid", ib.rsp_valid, 64'h0);
            tick();
        end
        chk("settle_rsp_valid", ib.rsp_valid, 64'h1);
        chk("settle_rsp_data", ib.rsp_data, 64'h000000BB000000AA);
        tick();

        // Reset in the second ISSUE cycle
        ib.req0_valid = 1'b1; ib.req0_a = 32'h11; ib.req0_b = 32'h22; ib.req0_sel = 5'h07;
        tick();
        ib.req0_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", ib.rsp_valid, 64'h0);
        chk("midrst_alu_a", ib.alu_a, 64'h0);
        chk("midrst_alu_b", ib.alu_b, 64'h0);
        chk("midrst_alu_sel", ib.alu_sel, 64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("postrst_no_rsp", ib.rsp_valid, 64'h0);
        end
        ib.req0_valid = 1'b1;
        ib.req1_valid = 1'b1;
        #1;
        chk("postrst_ready0", ib.req0_ready, 64'h1);
        chk("postrst_ready1", ib.req1_ready, 64'h0);
        ib.req0_valid = 1'b0;
        ib.req1_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
